s100_mem_cycle: RTL and testbench

Off-board memory cycle generator for the Z80 FPGA SBC. When the Z80 core issues a memory read or write that no on-board decoder claims (ROM, RAM and VGA RAM chip selects all inactive), this block runs the matching S100 bus memory cycle: it drives address, status and strobes, and holds the CPU in wait until the bus slave signals ready or a timeout expires. It sits between the core's memory request signals and the S100 bus pins, in parallel with the on-board memory decoder.

---
 rtl/s100_pkg.sv | 16 +
 rtl/s100_rdy_sync.sv | 21 ++
 rtl/s100_mem_cycle.sv | 134 +++++++++++++
 tb/tb_s100_mem_cycle.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/s100_pkg.sv
// Shared types and constants for the S100 off-board memory cycle generator.
package s100_pkg;

   localparam int S100_ADR_W  = 16;
   localparam int S100_DATA_W = 8;

   localparam logic [S100_DATA_W-1:0] S100_FLOAT_DATA = 8'hFF;

   typedef enum logic [1:0] {
      IDLE,
      SYNC,
      STROBE,
      DONE
   } s100_state_t;

endpackage

// File: rtl/s100_rdy_sync.sv
// Two-flop synchronizer for one asynchronous S100 ready line.
module s100_rdy_sync (
   input  logic clock,
   input  logic reset,
   input  logic async_in,
   output logic sync_out
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta     <= 1'b0;
         sync_out <= 1'b0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/s100_mem_cycle.sv
// Runs an S100 memory read/write cycle for CPU accesses no on-board device claims,
// holding the CPU in wait until the slave is ready or the strobe phase times out.
module s100_mem_cycle
   import s100_pkg::*;
#(
   parameter int STROBE_MIN = 2,
   parameter int TIMEOUT    = 255
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   req_rd,
   input  logic                   req_wr,
   input  logic                   local_sel,
   input  logic [S100_ADR_W-1:0]  address,
   input  logic [S100_DATA_W-1:0] wr_data,
   output logic [S100_DATA_W-1:0] rd_data,
   output logic                   cpu_wait,
   output logic [S100_ADR_W-1:0]  s100_adr,
   output logic [S100_DATA_W-1:0] s100_dout,
   input  logic [S100_DATA_W-1:0] s100_din,
   output logic                   s100_sync,
   output logic                   s100_smemr,
   output logic                   s100_pdbin,
   output logic                   s100_pwr_n,
   input  logic                   s100_rdy,
   input  logic                   s100_xrdy,
   output logic                   bus_timeout
);

   localparam logic [7:0] STROBE_MIN_C = 8'(STROBE_MIN);
   localparam logic [7:0] TIMEOUT_C    = 8'(TIMEOUT);

   s100_state_t state;
   logic [7:0]  count;
   logic        dir_rd;
   logic        rdy_s;
   logic        xrdy_s;
   logic        ready;
   logic        start;

   s100_rdy_sync u_rdy_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (s100_rdy),
      .sync_out (rdy_s)
   );

   s100_rdy_sync u_xrdy_sync (
      .clock    (clock),
      .reset    (reset),
      .async_in (s100_xrdy),
      .sync_out (xrdy_s)
   );

   assign ready = rdy_s & xrdy_s;
   assign start = (req_rd | req_wr) & ~local_sel;

   // Outputs are set on the transition into each state so every pin is a flop.
   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         count       <= 8'd0;
         dir_rd      <= 1'b0;
         rd_data     <= S100_FLOAT_DATA;
         cpu_wait    <= 1'b0;
         s100_adr    <= '0;
         s100_dout   <= '0;
         s100_sync   <= 1'b0;
         s100_smemr  <= 1'b0;
         s100_pdbin  <= 1'b0;
         s100_pwr_n  <= 1'b1;
         bus_timeout <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state      <= SYNC;
                  dir_rd     <= req_rd;
                  s100_adr   <= address;
                  s100_dout  <= wr_data;
                  s100_sync  <= 1'b1;
                  s100_smemr <= req_rd;
                  cpu_wait   <= 1'b1;
               end
            end

            SYNC: begin
               state      <= STROBE;
               count      <= 8'd1;
               s100_sync  <= 1'b0;
               s100_pdbin <= dir_rd;
               s100_pwr_n <= dir_rd;
            end

            // Ready is checked before timeout so a late ready still returns real data.
            STROBE: begin
               if (count >= STROBE_MIN_C && ready) begin
                  state      <= DONE;
                  s100_pdbin <= 1'b0;
                  s100_pwr_n <= 1'b1;
                  s100_smemr <= 1'b0;
                  cpu_wait   <= 1'b0;
                  if (dir_rd) begin
                     rd_data <= s100_din;
                  end
               end else if (count == TIMEOUT_C) begin
                  state       <= DONE;
                  s100_pdbin  <= 1'b0;
                  s100_pwr_n  <= 1'b1;
                  s100_smemr  <= 1'b0;
                  cpu_wait    <= 1'b0;
                  bus_timeout <= 1'b1;
                  if (dir_rd) begin
                     rd_data <= S100_FLOAT_DATA;
                  end
               end else begin
                  count <= count + 8'd1;
               end
            end

            DONE: begin
               if (!req_rd && !req_wr) begin
                  state <= IDLE;
               end
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_s100_mem_cycle.sv
// Directed self-checking bench for s100_mem_cycle with default parameters.
module tb_s100_mem_cycle;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_rd;
   logic        req_wr;
   logic        local_sel;
   logic [15:0] address;
   logic [7:0]  wr_data;
   logic [7:0]  rd_data;
   logic        cpu_wait;
   logic [15:0] s100_adr;
   logic [7:0]  s100_dout;
   logic [7:0]  s100_din;
   logic        s100_sync;
   logic        s100_smemr;
   logic        s100_pdbin;
   logic        s100_pwr_n;
   logic        s100_rdy;
   logic        s100_xrdy;
   logic        bus_timeout;

   int checks   = 0;
   int failures = 0;

   always #5 clock = ~clock;

   s100_mem_cycle dut (
      .clock       (clock),
      .reset       (reset),
      .req_rd      (req_rd),
      .req_wr      (req_wr),
      .local_sel   (local_sel),
      .address     (address),
      .wr_data     (wr_data),
      .rd_data     (rd_data),
      .cpu_wait    (cpu_wait),
      .s100_adr    (s100_adr),
      .s100_dout   (s100_dout),
      .s100_din    (s100_din),
      .s100_sync   (s100_sync),
      .s100_smemr  (s100_smemr),
      .s100_pdbin  (s100_pdbin),
      .s100_pwr_n  (s100_pwr_n),
      .s100_rdy    (s100_rdy),
      .s100_xrdy   (s100_xrdy),
      .bus_timeout (bus_timeout)
   );

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic check_output(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      int wait_cnt;
      int sync_cnt;
      bit seen_wait;

      reset     = 1'b1;
      req_rd    = 1'b0;
      req_wr    = 1'b0;
      local_sel = 1'b0;
      address   = 16'h0000;
      wr_data   = 8'h00;
      s100_din  = 8'h00;
      s100_rdy  = 1'b1;
      s100_xrdy = 1'b1;
      step();
      step();

      check_output("rst_rd_data", 32'(rd_data), 32'hFF);
      check_output("rst_cpu_wait", 32'(cpu_wait), 32'h0);
      check_output("rst_adr", 32'(s100_adr), 32'h0);
      check_output("rst_pwr_n", 32'(s100_pwr_n), 32'h1);
      check_output("rst_pdbin", 32'(s100_pdbin), 32'h0);
      check_output("rst_timeout", 32'(bus_timeout), 32'h0);

      reset = 1'b0;
      step();
      step();
      step();

      // Fast read: slave always ready.
      req_rd   = 1'b1;
      address  = 16'h8123;
      s100_din = 8'h5A;
      step();
      check_output("rd_e0_sync", 32'(s100_sync), 32'h1);
      check_output("rd_e0_smemr", 32'(s100_smemr), 32'h1);
      check_output("rd_e0_wait", 32'(cpu_wait), 32'h1);
      check_output("rd_e0_adr", 32'(s100_adr), 32'h8123);
      check_output("rd_e0_pdbin", 32'(s100_pdbin), 32'h0);
      step();
      check_output("rd_e1_sync", 32'(s100_sync), 32'h0);
      check_output("rd_e1_pdbin", 32'(s100_pdbin), 32'h1);
      check_output("rd_e1_wait", 32'(cpu_wait), 32'h1);
      step();
      check_output("rd_e2_pdbin", 32'(s100_pdbin), 32'h1);
      check_output("rd_e2_wait", 32'(cpu_wait), 32'h1);
      step();
      check_output("rd_e3_pdbin", 32'(s100_pdbin), 32'h0);
      check_output("rd_e3_wait", 32'(cpu_wait), 32'h0);
      check_output("rd_e3_smemr", 32'(s100_smemr), 32'h0);
      check_output("rd_e3_data", 32'(rd_data), 32'h5A);
      req_rd = 1'b0;
      step();

      // Slow write: RDY low, raised after the tenth edge following SYNC.
      s100_rdy = 1'b0;
      step();
      step();
      req_wr  = 1'b1;
      address = 16'h1234;
      wr_data = 8'h3C;
      step();
      check_output("wr_e0_sync", 32'(s100_sync), 32'h1);
      check_output("wr_e0_smemr", 32'(s100_smemr), 32'h0);
      for (int k = 1; k <= 10; k++) begin
         step();
         check_output($sformatf("wr_e%0d_pwr_n", k), 32'(s100_pwr_n), 32'h0);
         check_output($sformatf("wr_e%0d_wait", k), 32'(cpu_wait), 32'h1);
         check_output($sformatf("wr_e%0d_dout", k), 32'(s100_dout), 32'h3C);
      end
      s100_rdy = 1'b1;
      step();
      check_output("wr_e11_pwr_n", 32'(s100_pwr_n), 32'h0);
      step();
      check_output("wr_e12_pwr_n", 32'(s100_pwr_n), 32'h0);
      step();
      check_output("wr_e13_pwr_n", 32'(s100_pwr_n), 32'h1);
      check_output("wr_e13_wait", 32'(cpu_wait), 32'h0);
      check_output("wr_rd_data_kept", 32'(rd_data), 32'h5A);
      check_output("wr_timeout", 32'(bus_timeout), 32'h0);
      req_wr = 1'b0;
      step();

      // Locally claimed access must not touch the bus.
      local_sel = 1'b1;
      req_rd    = 1'b1;
      for (int k = 0; k < 5; k++) begin
         step();
         check_output("local_sync", 32'(s100_sync), 32'h0);
         check_output("local_wait", 32'(cpu_wait), 32'h0);
         check_output("local_pdbin", 32'(s100_pdbin), 32'h0);
      end
      req_rd    = 1'b0;
      local_sel = 1'b0;
      step();

      // Timeout read: RDY stuck low.
      s100_rdy  = 1'b0;
      step();
      step();
      step();
      req_rd    = 1'b1;
      wait_cnt  = 0;
      seen_wait = 1'b0;
      for (int k = 0; k < 400; k++) begin
         step();
         if (cpu_wait) begin
            wait_cnt++;
            seen_wait = 1'b1;
         end else if (seen_wait) begin
            break;
         end
      end
      check_output("to_wait_cycles", 32'(wait_cnt), 32'd256);
      check_output("to_rd_data", 32'(rd_data), 32'hFF);
      check_output("to_flag", 32'(bus_timeout), 32'h1);
      req_rd = 1'b0;
      step();

      // Held request: exactly one cycle until the request drops.
      s100_rdy = 1'b1;
      s100_din = 8'hA5;
      step();
      step();
      step();
      req_rd   = 1'b1;
      sync_cnt = 0;
      for (int k = 0; k < 25; k++) begin
         step();
         if (s100_sync) sync_cnt++;
      end
      check_output("held_sync_count", 32'(sync_cnt), 32'd1);
      check_output("held_wait", 32'(cpu_wait), 32'h0);
      check_output("held_rd_data", 32'(rd_data), 32'hA5);
      req_rd = 1'b0;
      step();
      req_rd   = 1'b1;
      s100_din = 8'h77;
      sync_cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (s100_sync) sync_cnt++;
      end
      check_output("retrig_sync_count", 32'(sync_cnt), 32'd1);
      check_output("retrig_rd_data", 32'(rd_data), 32'h77);
      check_output("sticky_timeout", 32'(bus_timeout), 32'h1);
      req_rd = 1'b0;
      step();

      // Reset during a read strobe.
      s100_rdy = 1'b0;
      step();
      step();
      step();
      req_rd = 1'b1;
      step();
      step();
      step();
      check_output("rstrd_pre_pdbin", 32'(s100_pdbin), 32'h1);
      reset  = 1'b1;
      req_rd = 1'b0;
      step();
      check_output("rstrd_pdbin", 32'(s100_pdbin), 32'h0);
      check_output("rstrd_pwr_n", 32'(s100_pwr_n), 32'h1);
      check_output("rstrd_wait", 32'(cpu_wait), 32'h0);
      check_output("rstrd_rd_data", 32'(rd_data), 32'hFF);
      check_output("rstrd_timeout", 32'(bus_timeout), 32'h0);
      reset = 1'b0;
      step();

      // Reset during a write strobe.
      req_wr = 1'b1;
      step();
      step();
      step();
      check_output("rstwr_pre_pwr_n", 32'(s100_pwr_n), 32'h0);
      reset  = 1'b1;
      req_wr = 1'b0;
      step();
      check_output("rstwr_pwr_n", 32'(s100_pwr_n), 32'h1);
      check_output("rstwr_wait", 32'(cpu_wait), 32'h0);
      reset = 1'b0;
      step();
      step();
      check_output("rstwr_idle_sync", 32'(s100_sync), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
